// File: rtl/aimbot_pkg.sv
// Shared constants and types for the UDP box-command path.
// The optional BOX_WRITER_SEQ_EN build uses SEQ_HDR_BYTES for its frame header.
package aimbot_pkg;

  localparam int unsigned BOX_BYTES     = 6;
  localparam int unsigned REC_W         = BOX_BYTES * 8;
  localparam int unsigned SEQ_HDR_BYTES = 2;

  // Bit positions inside one 48-bit big-endian box record
  localparam int unsigned SX_MSB  = 47;
  localparam int unsigned SX_LSB  = 37;
  localparam int unsigned SY_MSB  = 36;
  localparam int unsigned SY_LSB  = 27;
  localparam int unsigned EX_MSB  = 26;
  localparam int unsigned EX_LSB  = 16;
  localparam int unsigned EY_MSB  = 15;
  localparam int unsigned EY_LSB  = 6;
  localparam int unsigned COL_MSB = 5;
  localparam int unsigned COL_LSB = 0;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StReq,
    StSend,
    StDone
  } box_wr_state_e;

endpackage

// File: rtl/udp_box_encode.sv
// Combinational packer: one box's coordinates and colour into a 48-bit record.
module udp_box_encode
  import aimbot_pkg::*;
#(
  parameter int unsigned XW    = 11,
  parameter int unsigned YW    = 10,
  parameter int unsigned C_DEP = 2
) (
  input  logic [XW-1:0]    start_x,
  input  logic [YW-1:0]    start_y,
  input  logic [XW-1:0]    end_x,
  input  logic [YW-1:0]    end_y,
  input  logic [23:0]      color,
  output logic [REC_W-1:0] record
);

  // Only the top C_DEP bits of each channel travel; the rest are dropped.
  logic unused_color_bits;
  assign unused_color_bits = ^color;

  always_comb begin
    record                  = '0;
    record[SX_MSB:SX_LSB]   = start_x;
    record[SY_MSB:SY_LSB]   = start_y;
    record[EX_MSB:EX_LSB]   = end_x;
    record[EY_MSB:EY_LSB]   = end_y;
    record[COL_MSB:COL_LSB] = {color[23 -: C_DEP], color[15 -: C_DEP], color[7 -: C_DEP]};
  end

endmodule

// File: rtl/udp_box_writer.sv
// Snapshots the draw-box set and serves it byte-by-byte to the UDP packet engine.
// Define BOX_WRITER_SEQ_EN to prepend a 16-bit big-endian frame sequence number.
module udp_box_writer
  import aimbot_pkg::*;
#(
  parameter int unsigned BOX_NUM  = 1,
  parameter int unsigned H_ACT    = 1280,
  parameter int unsigned V_ACT    = 720,
  parameter int unsigned C_DEP    = 2,
  parameter int unsigned REQ_TICK = 1_000_000
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        send,
  input  logic [BOX_NUM*$clog2(H_ACT)-1:0] start_xs,
  input  logic [BOX_NUM*$clog2(V_ACT)-1:0] start_ys,
  input  logic [BOX_NUM*$clog2(H_ACT)-1:0] end_xs,
  input  logic [BOX_NUM*$clog2(V_ACT)-1:0] end_ys,
  input  logic [BOX_NUM*24-1:0]       colors,
  output logic                        trig,
  input  logic                        read_en,
  output logic [7:0]                  tx_data,
  output logic [15:0]                 data_len,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned XW = $clog2(H_ACT);
  localparam int unsigned YW = $clog2(V_ACT);
  localparam int unsigned TW = $clog2(REQ_TICK + 1);
`ifdef BOX_WRITER_SEQ_EN
  localparam int unsigned LEN = BOX_NUM * BOX_BYTES + SEQ_HDR_BYTES;
`else
  localparam int unsigned LEN = BOX_NUM * BOX_BYTES;
`endif
  localparam int unsigned PW = LEN * 8;

  if (2 * XW + 2 * YW + 3 * C_DEP != REC_W) begin : g_bad_layout
    $error("udp_box_writer: 2*XW + 2*YW + 3*C_DEP must equal 48");
  end

  box_wr_state_e state_q, state_d;
  logic [15:0]   idx_q, idx_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          snap_load;

  logic [BOX_NUM*XW-1:0] snap_sx, snap_ex;
  logic [BOX_NUM*YW-1:0] snap_sy, snap_ey;
  logic [BOX_NUM*24-1:0] snap_col;
  logic [BOX_NUM*REC_W-1:0] recs;
  logic [PW-1:0]            payload;
  logic [7:0]               byte_sel;

`ifdef BOX_WRITER_SEQ_EN
  logic [15:0] seq_q, seq_d;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_sx  <= '0;
      snap_sy  <= '0;
      snap_ex  <= '0;
      snap_ey  <= '0;
      snap_col <= '0;
    end else if (snap_load) begin
      snap_sx  <= start_xs;
      snap_sy  <= start_ys;
      snap_ex  <= end_xs;
      snap_ey  <= end_ys;
      snap_col <= colors;
    end
  end

  // Box 0 lands in the most significant record so it is served first.
  for (genvar g = 0; g < BOX_NUM; g++) begin : g_enc
    udp_box_encode #(
      .XW    (XW),
      .YW    (YW),
      .C_DEP (C_DEP)
    ) u_enc (
      .start_x (snap_sx[g*XW +: XW]),
      .start_y (snap_sy[g*YW +: YW]),
      .end_x   (snap_ex[g*XW +: XW]),
      .end_y   (snap_ey[g*YW +: YW]),
      .color   (snap_col[g*24 +: 24]),
      .record  (recs[(BOX_NUM-1-g)*REC_W +: REC_W])
    );
  end

`ifdef BOX_WRITER_SEQ_EN
  assign payload = {seq_q, recs};
`else
  assign payload = recs;
`endif

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < LEN; i++) begin
      if (idx_q == 16'(i)) byte_sel = payload[(LEN-1-i)*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef BOX_WRITER_SEQ_EN
      seq_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef BOX_WRITER_SEQ_EN
      seq_q     <= seq_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    snap_load = 1'b0;
`ifdef BOX_WRITER_SEQ_EN
    seq_d     = seq_q;
`endif
    // A strobe outside REQ/SEND is an overrun; it never alters the state flow.
    if (read_en && state_q != StReq && state_q != StSend) begin
      tx_data_d = '0;
      err_d     = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (send) state_d = StLatch;
      end
      StLatch: begin
        snap_load = 1'b1;
        idx_d     = '0;
        cnt_d     = '0;
        state_d   = StReq;
      end
      StReq: begin
        if (read_en) begin
          tx_data_d = byte_sel;
          idx_d     = idx_q + 16'd1;
          state_d   = (idx_q == 16'(LEN - 1)) ? StDone : StSend;
        end else if (cnt_q == TW'(REQ_TICK - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      StSend: begin
        if (read_en) begin
          tx_data_d = byte_sel;
          idx_d     = idx_q + 16'd1;
          if (idx_q == 16'(LEN - 1)) state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
`ifdef BOX_WRITER_SEQ_EN
        seq_d   = seq_q + 16'd1;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  assign trig     = (state_q == StReq);
  assign busy     = (state_q != StIdle);
  assign tx_data  = tx_data_q;
  assign done     = done_q;
  assign err      = err_q;
  assign data_len = 16'(LEN);

endmodule

// File: tb/tb_udp_box_writer.sv
// Directed self-checking bench for udp_box_writer (BOX_NUM=1, REQ_TICK=100).
module tb_udp_box_writer;

`ifdef BOX_WRITER_SEQ_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int LEN = 6 + HDR;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        send = 1'b0;
  logic [10:0] start_xs = '0, end_xs = '0;
  logic [9:0]  start_ys = '0, end_ys = '0;
  logic [23:0] colors = '0;
  logic        trig, read_en = 1'b0;
  logic [7:0]  tx_data;
  logic [15:0] data_len;
  logic        busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_seq = '0;
  logic [7:0]  box_bytes [6] = '{8'h0C, 8'h81, 8'h91, 8'h2C, 8'h32, 8'h30};

  always #5 clk = ~clk;

  udp_box_writer #(
    .BOX_NUM  (1),
    .H_ACT    (1280),
    .V_ACT    (720),
    .C_DEP    (2),
    .REQ_TICK (100)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .send     (send),
    .start_xs (start_xs),
    .start_ys (start_ys),
    .end_xs   (end_xs),
    .end_ys   (end_ys),
    .colors   (colors),
    .trig     (trig),
    .read_en  (read_en),
    .tx_data  (tx_data),
    .data_len (data_len),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    if (i < HDR) return (i == 0) ? exp_seq[15:8] : exp_seq[7:0];
    return box_bytes[i - HDR];
  endfunction

  task automatic set_box();
    start_xs = 11'd100;
    start_ys = 10'd50;
    end_xs   = 11'd300;
    end_ys   = 10'd200;
    colors   = 24'hFF0000;
  endtask

  // Pulse send and advance into REQ, checking the two-cycle trig latency.
  task automatic start_packet();
    send = 1'b1;
    tick();
    send = 1'b0;
    check("latch_trig_low", 16'(trig), 16'd0);
    check("latch_busy", 16'(busy), 16'd1);
    tick();
    check("req_trig_high", 16'(trig), 16'd1);
  endtask

  task automatic read_packet(input int gap);
    for (int i = 0; i < LEN; i++) begin
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      check($sformatf("byte%0d", i), 16'(tx_data), 16'(exp_byte(i)));
      check("send_trig_low", 16'(trig), 16'd0);
      if (i < LEN - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check($sformatf("hold%0d", i), 16'(tx_data), 16'(exp_byte(i)));
          check("gap_no_err", 16'(err), 16'd0);
        end
      end
    end
    check("done_not_yet", 16'(done), 16'd0);
    tick();
    check("done_pulse", 16'(done), 16'd1);
    check("done_idle", 16'(busy), 16'd0);
    check("done_no_err", 16'(err), 16'd0);
    tick();
    check("done_clear", 16'(done), 16'd0);
`ifdef BOX_WRITER_SEQ_EN
    exp_seq = exp_seq + 16'd1;
`endif
  endtask

  initial begin
    int hi_cycles;
    #2;
    check("rst_trig", 16'(trig), 16'd0);
    check("rst_tx_data", 16'(tx_data), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_err", 16'(err), 16'd0);
    check("data_len", data_len, 16'(LEN));
    tick();
    rstn = 1'b1;
    tick();

    // Basic packet, then one with read gaps (second packet exercises seq=1)
    set_box();
    start_packet();
    read_packet(0);
    start_packet();
    read_packet(2);

    // Inputs change after the snapshot is taken
    start_packet();
    start_xs = '0; start_ys = '0; end_xs = '0; end_ys = '0; colors = '0;
    read_packet(0);
    set_box();

    // Overrun while idle
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check("ovr_err", 16'(err), 16'd1);
    check("ovr_tx_zero", 16'(tx_data), 16'd0);
    check("ovr_idle", 16'(busy), 16'd0);
    tick();
    check("ovr_err_clear", 16'(err), 16'd0);

    // REQ timeout with no read_en
    start_packet();
    hi_cycles = 1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (!trig) break;
      hi_cycles++;
    end
    check("timeout_cycles", 16'(hi_cycles), 16'd100);
    check("timeout_err", 16'(err), 16'd1);
    check("timeout_idle", 16'(busy), 16'd0);
    check("timeout_trig", 16'(trig), 16'd0);
    tick();
    check("timeout_err_clear", 16'(err), 16'd0);

    // Asynchronous reset mid-SEND after byte 3
    start_packet();
    for (int i = 0; i < 4; i++) begin
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      check($sformatf("part%0d", i), 16'(tx_data), 16'(exp_byte(i)));
    end
    #2;
    rstn = 1'b0;
    #1;
    check("arst_trig", 16'(trig), 16'd0);
    check("arst_tx_data", 16'(tx_data), 16'd0);
    check("arst_busy", 16'(busy), 16'd0);
    exp_seq = '0;
    tick();
    rstn = 1'b1;
    tick();
    start_packet();
    read_packet(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_box_writer.md
# udp_box_writer

Transmit-side counterpart of the UDP box-command path. It latches the current draw-box set (start/end coordinates and colours) and serializes it into the same 6-byte-per-box payload format the receive-side reader/parser consumes. It serves that payload byte-by-byte to the UDP packet engine through the trig / tx_read_en / tx_data handshake. It sits in the rgmii_clk domain beside the line buffer and gives the host a loopback/echo of the boxes currently drawn.

## Interface
- BOX_NUM, 1, number of boxes per payload
- H_ACT, 1280, active width; X field width XW = $clog2(H_ACT)
- V_ACT, 720, active height; Y field width YW = $clog2(V_ACT)
- C_DEP, 2, retained bits per colour channel
- REQ_TICK, 1_000_000, clk cycles to wait for first read_en before abort
- clk  in  1  rgmii_clk domain; all logic on posedge
- rstn  in  1  asynchronous, active-low reset
- send  in  1  request pulse; sampled in IDLE only
- start_xs / end_xs  in  BOX_NUM*XW  box i at slice [i*XW +: XW]
- start_ys / end_ys  in  BOX_NUM*YW  box i at slice [i*YW +: YW]
- colors  in  BOX_NUM*24  box i at [i*24 +: 24] = {R,G,B}
- trig  out  1  payload-ready request to packet engine
- read_en  in  1  byte strobe from packet engine
- tx_data  out  8  payload byte
- data_len  out  16  payload length in bytes, constant
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last byte is served
- err  out  1  one-cycle pulse on REQ timeout or read overrun

## Operation
- Elaboration check: 2*XW + 2*YW + 3*C_DEP must equal 48. Otherwise `$error`.
- data_len = 6*BOX_NUM (+2 with the macro).
- Per-box record, big-endian, MSB first: [47:37] start_x, [36:27] start_y, [26:16] end_x, [15:6] end_y, [5:0] {R[7:8-C_DEP], G[..], B[..]}. Box 0 first.
- FSM states: IDLE, LATCH, REQ, SEND, DONE.
- IDLE: on send=1, go to LATCH.
- LATCH: register all box inputs into a snapshot (inputs may change afterwards), clear byte index, go to REQ.
- REQ: trig=1 (level). On first read_en=1, go to SEND. If REQ_TICK cycles pass without read_en, pulse err and return to IDLE.
- SEND: trig=0. Each read_en=1 cycle serves byte[idx], then idx++. read_en=0 pauses; idx holds. After byte data_len-1 is served, go to DONE.
- DONE: pulse done for one cycle, return to IDLE.
- Any read_en while in IDLE, LATCH or DONE is an overrun: tx_data=0, err pulses, state is unchanged.
- send while busy is ignored. It is not queued.

## Timing
- Reset values: trig=0, tx_data=8'h00, busy=0, done=0, err=0, state IDLE, idx=0. data_len is constant.
- send at edge N: LATCH at N+1, trig high from N+2.
- Read latency is 1 cycle, registered. When read_en is high at edge k, tx_data holds the addressed byte from edge k+1 onward, until the next read_en.
- The REQ→SEND transition consumes byte 0, i.e. the first read_en also reads.
- done rises on the edge after the last byte's tx_data update.
- idx is 16 bits and never wraps; reaching data_len-1 ends the packet.
- rstn low at any time, including mid-SEND: asynchronous return to reset values. The partial packet is abandoned.

## Configuration
- BOX_WRITER_SEQ_EN defined: a 16-bit frame sequence number is prepended big-endian as bytes 0-1, and data_len = 6*BOX_NUM+2. The sequence number increments in DONE only, wraps 16'hFFFF→0, and resets to 0.
- BOX_WRITER_SEQ_EN undefined: no header. Byte 0 is box 0 byte 0, and data_len = 6*BOX_NUM.

## Structure
- Shared package aimbot_pkg holds BOX_BYTES=6, the field-position constants, the state enum and the SEQ header length.
- Sub-module udp_box_encode is purely combinational. It takes one box's coordinates and colour and produces the 48-bit record. It is generated per box on the snapshot.
- Top level holds the FSM, the snapshot registers, the index counter, the REQ_TICK counter and the byte mux.

## Test plan
- BOX_NUM=1, macro off, box (100,50,300,200), colors 24'hFF0000, send → trig high 2 cycles later. Six read_en strobes → tx_data 0x0C,0x81,0x91,0x2C,0x32,0x30, then done pulse; data_len=6.
- Same box, read_en toggled 1,0,0,1,... → tx_data holds during gaps, sequence unchanged, no err.
- send, then change inputs to all-zero in REQ → served bytes still the 0x0C... snapshot.
- send with read_en never asserted, REQ_TICK=100 → trig high 100 cycles, err pulse, busy=0, trig=0.
- rstn low after byte 3, then a new send → trig=0 and tx_data=0 immediately on reset. The new packet starts at byte 0 (0x0C).
- Macro on, two sends → first packet header 0x00,0x00, second 0x00,0x01, data_len=8.
